tl_bank_buffer: RTL and testbench
=================================

# tl_bank_buffer

Registered TileLink-UL buffer stage directly downstream of the bank binder, between it and the memory bank's TileLink port. It decouples timing on the A and D channels with independent FIFOs. It also enforces a cap on outstanding transactions by counting request messages issued downstream against response messages returned. The stage is protocol-transparent: every field passes through unchanged, in order.

## Interface
- A_DEPTH, 2, A-channel FIFO entries (power of 2, ≥2)
- D_DEPTH, 2, D-channel FIFO entries (power of 2, ≥2)
- MAX_INFLIGHT, 4, max request messages issued on auto_out_a without a completed D response (1..15)
- clock  input  1  sole clock; all state on rising edge
- reset  input  1  asynchronous, active-low; asserting clears all state immediately, deassertion is synchronous to clock
- auto_in_a_ready  output  1  A FIFO can accept a beat
- auto_in_a_valid  input  1  upstream A beat valid
- auto_in_a_bits_opcode / _param / _size  input  3 each  A fields
- auto_in_a_bits_source  input  4  A source ID
- auto_in_a_bits_address  input  32  byte address
- auto_in_a_bits_mask  input  8  byte mask
- auto_in_a_bits_data  input  64  write data
- auto_in_a_bits_corrupt  input  1  corrupt flag
- auto_out_a_valid / auto_out_a_ready  output / input  1  downstream A handshake
- auto_out_a_bits_*  output  same widths as auto_in_a_bits_*  FIFO head fields
- auto_out_d_ready  output  1  D FIFO can accept a beat
- auto_out_d_valid  input  1  downstream D beat valid
- auto_out_d_bits_opcode / _size  input  3 each; _source input 4; _denied, _corrupt input 1; _data input 64
- auto_in_d_valid / auto_in_d_ready  output / input  1  upstream D handshake
- auto_in_d_bits_*  output  same widths as auto_out_d_bits_*  D FIFO head fields

## Operation
- Two independent circular FIFOs with separate read/write pointers and a count register.
  - A FIFO: 118-bit entry covering all A fields.
  - D FIFO: 76-bit entry covering all D fields.
- Enqueue on valid&&ready. ready = (count != DEPTH). A full FIFO refuses enqueue even if it dequeues in the same cycle; there is no pipe bypass.
- Dequeue side: valid = (count != 0). Head data is driven from registered storage; there is no flow-through.
- Pointers wrap modulo DEPTH. On simultaneous enqueue and dequeue, count is unchanged.
- Beat counting, applied independently on each channel:
  - A messages with data: opcode 0, 1, 2, 3.
  - D messages with data: opcode 1.
  - beats = (size>3 && has data) ? 1<<(size-3) : 1.
  - The beat counter is loaded on the first beat. The last beat is when remaining == 1.
- Inflight counter, 4-bit:
  - +1 on the auto_out_a fire that is the last beat of a message.
  - −1 on the auto_in_d fire that is the last beat of a response.
  - Both in the same cycle leaves it unchanged.
  - Decrement at 0 saturates at 0.
- Issue gate:
  - auto_out_a_valid = A FIFO non-empty && (A mid-burst || inflight < MAX_INFLIGHT).
  - A burst that has started always completes; the gate is evaluated only at first beats.
- D path is never gated by inflight.

## Timing
- Reset values (asserted asynchronously):
  - auto_out_a_valid=0, auto_in_d_valid=0
  - auto_in_a_ready=1, auto_out_d_ready=1
  - inflight=0, both FIFO counts=0, beat counters idle
  - auto_out_a_bits_* and auto_in_d_bits_* are don't-care while valid=0.
- Latency: a beat enqueued at edge N is visible on the output side in cycle N+1 (1 cycle minimum, either channel).
- Throughput: one beat/cycle per channel in steady state with DEPTH ≥ 2.
- Valid/bits on the output side are held stable until the corresponding ready is sampled high.
- Reset mid-burst discards FIFO contents and partial beat state. Upstream and downstream must also be reset.

## Test plan
- Single Get (opcode 4, size 3, source 5, addr 0x8000_0000): auto_out_a_valid rises 1 cycle after the in-fire with identical fields. D AccessAckData returns on auto_in_d 1 cycle after the out-fire; inflight goes 0→1→0.
- Back-to-back 8 Gets, both readies held 1: one beat/cycle on auto_out_a. After 4 issued with no D returned, auto_out_a_valid=0 and the A FIFO fills (auto_in_a_ready=0 after 2 more). One D response reopens issue in the next cycle.
- PutFullData size 5 (4 beats) with inflight=3, MAX_INFLIGHT=4: all 4 beats issue and inflight becomes 4 only at the last beat. Any following message is held until a D fires.
- Full FIFO with simultaneous attempts: A count=2 and out-ready=1 in the same cycle as in-valid → auto_in_a_ready=0 that cycle, count=1 next cycle, enqueue accepted the cycle after.
- Backpressure on auto_in_d_ready=0 for 10 cycles with 3 responses arriving: auto_out_d_ready drops after 2. Responses are delivered in order with fields unchanged once auto_in_d_ready=1.
- Reset pulled low mid 4-beat Put with both FIFOs non-empty: all outputs reach reset values within the same cycle. After release a new Get completes normally with inflight starting at 0.

Source files
------------

// File: rtl/tl_bank_buffer.sv
// tl_bank_buffer: registered TileLink-UL stage between the bank binder and a
// memory bank. Independent A and D FIFOs decouple timing; an inflight counter
// caps request messages issued downstream that have not yet been answered.
//
// Handshake rule used on every channel: a beat transfers on a rising clock
// edge where valid && ready are both high. valid never depends on ready,
// valid/bits stay stable until the transfer, and ready depends only on
// registered state, so no combinational path runs from input to output.

// Circular FIFO with a count register, no bypass and no flow-through.
module tl_bank_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enq, deq;

  // A full FIFO refuses enqueue even when it dequeues in the same cycle.
  assign in_ready_o  = (cnt_q != CW'(DEPTH));
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = mem_q[rd_q];
  assign enq         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i;

  // Pointer and count next state; DEPTH is a power of two so pointers wrap.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (enq) wr_d = wr_q + 1'b1;
    if (deq) rd_d = rd_q + 1'b1;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage holds payload only, so it needs no reset.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_q] <= in_data_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// Tracks beats left in the current message; zero means the next fire is a first beat.
module tl_beat_track (
  input  logic       clock,
  input  logic       reset,
  input  logic       fire_i,
  input  logic [4:0] beats_i,
  output logic       last_o,
  output logic       mid_o
);
  logic [4:0] rem_q, rem_d;

  assign mid_o  = (rem_q != '0);
  assign last_o = mid_o ? (rem_q == 5'd1) : (beats_i == 5'd1);

  // Load on the first beat, count down on the rest; a 1-beat message stays idle.
  always_comb begin
    rem_d = rem_q;
    if (fire_i) rem_d = mid_o ? (rem_q - 5'd1) : (beats_i - 5'd1);
  end

  // Remaining-beat register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rem_q <= '0;
    else        rem_q <= rem_d;
  end
endmodule

module tl_bank_buffer #(
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [3:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_out_a_valid,
  input  logic        auto_out_a_ready,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [2:0]  auto_out_a_bits_size,
  output logic [3:0]  auto_out_a_bits_source,
  output logic [31:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [2:0]  auto_out_d_bits_size,
  input  logic [3:0]  auto_out_d_bits_source,
  input  logic        auto_out_d_bits_denied,
  input  logic        auto_out_d_bits_corrupt,
  input  logic [63:0] auto_out_d_bits_data,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [3:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_denied,
  output logic        auto_in_d_bits_corrupt,
  output logic [63:0] auto_in_d_bits_data
);
  logic [117:0] a_enq_data, a_head;
  logic [75:0]  d_enq_data, d_head;
  logic         a_fifo_valid, a_gate, a_fire, a_mid, a_last;
  logic         d_fire, d_mid, d_last;
  logic [4:0]   a_beats, d_beats;
  logic [3:0]   inflight_q, inflight_d;

  // Beats in a message: data-carrying sizes above 8 bytes span several 64-bit beats.
  function automatic logic [4:0] beats_of(input logic [2:0] size, input logic has_data);
    if (has_data && (size > 3'd3)) return 5'd1 << (size - 3'd3);
    return 5'd1;
  endfunction

  assign a_enq_data = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                       auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                       auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_head;

  assign d_enq_data = {auto_out_d_bits_opcode, auto_out_d_bits_size, auto_out_d_bits_source,
                       auto_out_d_bits_denied, auto_out_d_bits_corrupt, auto_out_d_bits_data};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source,
          auto_in_d_bits_denied, auto_in_d_bits_corrupt, auto_in_d_bits_data} = d_head;

  // A new message may start only below the cap; a started burst always finishes.
  assign a_gate           = a_mid || (inflight_q < 4'(MAX_INFLIGHT));
  assign auto_out_a_valid = a_fifo_valid && a_gate;
  assign a_fire           = auto_out_a_valid && auto_out_a_ready;
  assign a_beats          = beats_of(auto_out_a_bits_size, !auto_out_a_bits_opcode[2]);

  assign d_fire  = auto_in_d_valid && auto_in_d_ready;
  assign d_beats = beats_of(auto_in_d_bits_size, auto_in_d_bits_opcode == 3'd1);

  tl_bank_fifo #(.DEPTH(A_DEPTH), .W(118)) u_a_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (auto_in_a_valid),
    .in_ready_o  (auto_in_a_ready),
    .in_data_i   (a_enq_data),
    .out_valid_o (a_fifo_valid),
    .out_ready_i (auto_out_a_ready && a_gate),
    .out_data_o  (a_head)
  );

  tl_bank_fifo #(.DEPTH(D_DEPTH), .W(76)) u_d_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (auto_out_d_valid),
    .in_ready_o  (auto_out_d_ready),
    .in_data_i   (d_enq_data),
    .out_valid_o (auto_in_d_valid),
    .out_ready_i (auto_in_d_ready),
    .out_data_o  (d_head)
  );

  tl_beat_track u_a_beats (
    .clock   (clock),
    .reset   (reset),
    .fire_i  (a_fire),
    .beats_i (a_beats),
    .last_o  (a_last),
    .mid_o   (a_mid)
  );

  tl_beat_track u_d_beats (
    .clock   (clock),
    .reset   (reset),
    .fire_i  (d_fire),
    .beats_i (d_beats),
    .last_o  (d_last),
    .mid_o   (d_mid)
  );

  // Inflight: +1 per completed request message, -1 per completed response, floor at 0.
  always_comb begin
    inflight_d = inflight_q;
    case ({a_fire && a_last, d_fire && d_last})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = (inflight_q != 4'd0) ? (inflight_q - 4'd1) : 4'd0;
      default: inflight_d = inflight_q;
    endcase
  end

  // Inflight register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  logic unused_d_mid;
  assign unused_d_mid = d_mid;
endmodule

// File: tb/tb_tl_bank_buffer.sv
// Bench for tl_bank_buffer: directed scenarios feed both channels; every beat
// accepted upstream is queued as the expected output beat and a monitor pops
// and compares whenever the DUT transfers a beat on its output side.
module tb_tl_bank_buffer;
  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [117:0] a_in;
  logic         in_a_valid;
  logic         in_a_ready;
  logic         out_a_valid;
  logic         out_a_ready;
  logic [2:0]   oa_op, oa_param, oa_size;
  logic [3:0]   oa_src;
  logic [31:0]  oa_addr;
  logic [7:0]   oa_mask;
  logic [63:0]  oa_data;
  logic         oa_corrupt;
  logic [75:0]  d_in;
  logic         out_d_valid;
  logic         out_d_ready;
  logic         in_d_valid;
  logic         in_d_ready;
  logic [2:0]   id_op, id_size;
  logic [3:0]   id_src;
  logic         id_denied, id_corrupt;
  logic [63:0]  id_data;

  logic [117:0] a_out;
  logic [75:0]  d_out;
  assign a_out = {oa_op, oa_param, oa_size, oa_src, oa_addr, oa_mask, oa_data, oa_corrupt};
  assign d_out = {id_op, id_size, id_src, id_denied, id_corrupt, id_data};

  tl_bank_buffer #(.A_DEPTH(2), .D_DEPTH(2), .MAX_INFLIGHT(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_ready         (in_a_ready),
    .auto_in_a_valid         (in_a_valid),
    .auto_in_a_bits_opcode   (a_in[117:115]),
    .auto_in_a_bits_param    (a_in[114:112]),
    .auto_in_a_bits_size     (a_in[111:109]),
    .auto_in_a_bits_source   (a_in[108:105]),
    .auto_in_a_bits_address  (a_in[104:73]),
    .auto_in_a_bits_mask     (a_in[72:65]),
    .auto_in_a_bits_data     (a_in[64:1]),
    .auto_in_a_bits_corrupt  (a_in[0]),
    .auto_out_a_valid        (out_a_valid),
    .auto_out_a_ready        (out_a_ready),
    .auto_out_a_bits_opcode  (oa_op),
    .auto_out_a_bits_param   (oa_param),
    .auto_out_a_bits_size    (oa_size),
    .auto_out_a_bits_source  (oa_src),
    .auto_out_a_bits_address (oa_addr),
    .auto_out_a_bits_mask    (oa_mask),
    .auto_out_a_bits_data    (oa_data),
    .auto_out_a_bits_corrupt (oa_corrupt),
    .auto_out_d_ready        (out_d_ready),
    .auto_out_d_valid        (out_d_valid),
    .auto_out_d_bits_opcode  (d_in[75:73]),
    .auto_out_d_bits_size    (d_in[72:70]),
    .auto_out_d_bits_source  (d_in[69:66]),
    .auto_out_d_bits_denied  (d_in[65]),
    .auto_out_d_bits_corrupt (d_in[64]),
    .auto_out_d_bits_data    (d_in[63:0]),
    .auto_in_d_valid         (in_d_valid),
    .auto_in_d_ready         (in_d_ready),
    .auto_in_d_bits_opcode   (id_op),
    .auto_in_d_bits_size     (id_size),
    .auto_in_d_bits_source   (id_src),
    .auto_in_d_bits_denied   (id_denied),
    .auto_in_d_bits_corrupt  (id_corrupt),
    .auto_in_d_bits_data     (id_data)
  );

  // ---------------- scoreboard state ----------------
  logic [117:0] exp_a_q[$];
  logic [75:0]  exp_d_q[$];
  logic [117:0] exp_a_head;
  logic [75:0]  exp_d_head;
  int tests = 0;
  int fails = 0;

  function automatic logic [117:0] mk_a(input logic [2:0] op, input logic [2:0] size,
                                        input logic [3:0] src, input logic [31:0] addr,
                                        input logic [7:0] mask, input logic [63:0] data);
    return {op, 3'd0, size, src, addr, mask, data, 1'b0};
  endfunction

  function automatic logic [75:0] mk_d(input logic [2:0] op, input logic [2:0] size,
                                       input logic [3:0] src, input logic [63:0] data);
    return {op, size, src, 1'b0, 1'b0, data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  // Output beats are sampled on the falling edge, half a cycle before the transfer edge.
  always @(negedge clock) begin
    if (reset) begin
      if (out_a_valid && out_a_ready) begin
        tests++;
        if (exp_a_q.size() == 0) begin
          fails++;
          $display("FAIL a_beat: got unexpected beat %h expected none", a_out);
        end else begin
          exp_a_head = exp_a_q.pop_front();
          if (a_out !== exp_a_head) begin
            fails++;
            $display("FAIL a_beat: got %h expected %h", a_out, exp_a_head);
          end
        end
      end
      if (in_d_valid && in_d_ready) begin
        tests++;
        if (exp_d_q.size() == 0) begin
          fails++;
          $display("FAIL d_beat: got unexpected beat %h expected none", d_out);
        end else begin
          exp_d_head = exp_d_q.pop_front();
          if (d_out !== exp_d_head) begin
            fails++;
            $display("FAIL d_beat: got %h expected %h", d_out, exp_d_head);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic [117:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    a_in = b;
    in_a_valid = 1'b1;
    while (!acc && n < 60) begin
      @(negedge clock);
      acc = in_a_ready;
      n++;
      step();
    end
    in_a_valid = 1'b0;
    if (acc) exp_a_q.push_back(b);
    else check("a_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_d(input logic [75:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    d_in = b;
    out_d_valid = 1'b1;
    while (!acc && n < 60) begin
      @(negedge clock);
      acc = out_d_ready;
      n++;
      step();
    end
    out_d_valid = 1'b0;
    if (acc) exp_d_q.push_back(b);
    else check("d_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_a_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_a_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, exp_a_q.size(), 0);
  endtask

  task automatic wait_d_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_d_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, exp_d_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  logic [117:0] g;
  initial begin
    reset = 1'b0;
    in_a_valid = 1'b0;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    in_d_ready = 1'b0;
    a_in = '0;
    d_in = '0;
    repeat (3) step();
    check("rst_out_a_valid", out_a_valid, 0);
    check("rst_in_d_valid", in_d_valid, 0);
    check("rst_in_a_ready", in_a_ready, 1);
    check("rst_out_d_ready", out_d_ready, 1);
    reset = 1'b1;
    repeat (2) step();

    // Single Get, then its AccessAckData.
    out_a_ready = 1'b1;
    in_d_ready = 1'b1;
    g = mk_a(3'd4, 3'd3, 4'd5, 32'h8000_0000, 8'hff, 64'h0);
    a_in = g;
    in_a_valid = 1'b1;
    step();
    exp_a_q.push_back(g);
    in_a_valid = 1'b0;
    check("s1_out_a_valid", out_a_valid, 1);
    step();
    check("s1_out_a_idle", out_a_valid, 0);
    d_in = mk_d(3'd1, 3'd3, 4'd5, 64'hdead_beef_0000_0001);
    out_d_valid = 1'b1;
    step();
    exp_d_q.push_back(d_in);
    out_d_valid = 1'b0;
    check("s1_in_d_valid", in_d_valid, 1);
    step();
    check("s1_in_d_idle", in_d_valid, 0);

    // Full A FIFO with a dequeue and an enqueue attempt in the same cycle.
    out_a_ready = 1'b0;
    send_a(mk_a(3'd4, 3'd3, 4'd1, 32'h100, 8'hff, 64'h11));
    send_a(mk_a(3'd4, 3'd3, 4'd2, 32'h108, 8'hff, 64'h22));
    check("s4_full_ready", in_a_ready, 0);
    out_a_ready = 1'b1;
    g = mk_a(3'd4, 3'd3, 4'd3, 32'h110, 8'hff, 64'h33);
    a_in = g;
    in_a_valid = 1'b1;
    check("s4_ready_same_cycle", in_a_ready, 0);
    step();
    check("s4_ready_after_deq", in_a_ready, 1);
    step();
    exp_a_q.push_back(g);
    in_a_valid = 1'b0;
    wait_a_drain("s4_drain", 20);
    for (int i = 1; i <= 3; i++) send_d(mk_d(3'd1, 3'd3, 4'(i), 64'(i)));
    wait_d_drain("s4_d_drain", 20);

    // Eight back-to-back Gets against a cap of four.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_a(mk_a(3'd4, 3'd3, 4'(i), 32'h1000 + 32'(i * 8), 8'hff, 64'(i)));
      end
    join_none
    repeat (6) step();
    #2;
    check("s2_gate_closed", out_a_valid, 0);
    check("s2_a_fifo_full", in_a_ready, 0);
    check("s2_four_issued", exp_a_q.size(), 2);
    repeat (2) step();
    check("s2_gate_holds", out_a_valid, 0);
    d_in = mk_d(3'd1, 3'd3, 4'd0, 64'ha0);
    out_d_valid = 1'b1;
    step();
    exp_d_q.push_back(d_in);
    out_d_valid = 1'b0;
    check("s2_before_d_fire", out_a_valid, 0);
    step();
    check("s2_reopen", out_a_valid, 1);
    for (int i = 1; i < 8; i++) send_d(mk_d(3'd1, 3'd3, 4'(i), 64'ha0 + 64'(i)));
    wait fork;
    wait_a_drain("s2_a_drain", 40);
    wait_d_drain("s2_d_drain", 40);

    // D backpressure: three responses, upstream stalled for ten cycles.
    in_d_ready = 1'b0;
    fork
      begin
        send_d(mk_d(3'd1, 3'd3, 4'd7, 64'h7001));
        send_d(mk_d(3'd0, 3'd2, 4'd8, 64'h0));
        send_d(mk_d(3'd1, 3'd3, 4'd9, 64'h7003));
      end
    join_none
    repeat (3) step();
    #2;
    check("s5_d_ready_low", out_d_ready, 0);
    check("s5_d_valid_held", in_d_valid, 1);
    check("s5_two_accepted", exp_d_q.size(), 2);
    repeat (7) step();
    in_d_ready = 1'b1;
    wait fork;
    wait_d_drain("s5_d_drain", 20);

    // Four-beat Put issued with three Gets outstanding.
    for (int i = 0; i < 3; i++) send_a(mk_a(3'd4, 3'd3, 4'(i), 32'h3000 + 32'(i * 8), 8'hff, 64'h0));
    wait_a_drain("s3_gets_issued", 20);
    for (int b = 0; b < 4; b++)
      send_a(mk_a(3'd0, 3'd5, 4'd9, 32'h2000 + 32'(b * 8), 8'hff, 64'hcafe_0000 + 64'(b)));
    send_a(mk_a(3'd4, 3'd3, 4'd10, 32'h4000, 8'hff, 64'h0));
    repeat (4) step();
    check("s3_put_done_get_held", exp_a_q.size(), 1);
    check("s3_gate_closed", out_a_valid, 0);
    send_d(mk_d(3'd1, 3'd4, 4'd0, 64'hb001));
    wait_d_drain("s3_d_beat1", 10);
    repeat (2) step();
    check("s3_held_mid_d_burst", exp_a_q.size(), 1);
    send_d(mk_d(3'd1, 3'd4, 4'd0, 64'hb002));
    wait_a_drain("s3_release", 10);
    send_d(mk_d(3'd1, 3'd3, 4'd1, 64'hb003));
    send_d(mk_d(3'd1, 3'd3, 4'd2, 64'hb004));
    send_d(mk_d(3'd0, 3'd5, 4'd9, 64'h0));
    send_d(mk_d(3'd1, 3'd3, 4'd10, 64'hb005));
    wait_d_drain("s3_d_drain", 20);

    // Reset in the middle of a four-beat Put with both FIFOs occupied.
    in_d_ready = 1'b0;
    send_a(mk_a(3'd0, 3'd5, 4'd6, 32'h5000, 8'hff, 64'h51));
    send_a(mk_a(3'd0, 3'd5, 4'd6, 32'h5008, 8'hff, 64'h52));
    out_a_ready = 1'b0;
    send_a(mk_a(3'd0, 3'd5, 4'd6, 32'h5010, 8'hff, 64'h53));
    send_d(mk_d(3'd1, 3'd3, 4'd6, 64'h61));
    #2;
    reset = 1'b0;
    #1;
    check("s6_rst_out_a_valid", out_a_valid, 0);
    check("s6_rst_in_d_valid", in_d_valid, 0);
    check("s6_rst_in_a_ready", in_a_ready, 1);
    check("s6_rst_out_d_ready", out_d_ready, 1);
    exp_a_q.delete();
    exp_d_q.delete();
    repeat (2) step();
    reset = 1'b1;
    out_a_ready = 1'b1;
    in_d_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send_a(mk_a(3'd4, 3'd3, 4'(i), 32'h6000 + 32'(i * 8), 8'hff, 64'h0));
    wait_a_drain("s6_four_issue", 20);
    send_a(mk_a(3'd4, 3'd3, 4'd4, 32'h6020, 8'hff, 64'h0));
    repeat (3) step();
    check("s6_fifth_held", exp_a_q.size(), 1);
    send_d(mk_d(3'd1, 3'd3, 4'd0, 64'h71));
    wait_a_drain("s6_fifth_released", 10);
    wait_d_drain("s6_d_drain", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
